icache_ctrl_nway: RTL and testbench

Parametrised N-way set-associative instruction cache controller FSM, the successor to the direct-mapped instruction cache FSM. It sits between the fetch stage and the cache tag/data arrays and the external memory read channel. Over the direct-mapped controller it adds:
- a read-request handshake;
- per-beat line fill with beat indexing and burst-length checking;
- victim way selection (first invalid way, otherwise per-set round-robin);
- a whole-cache flush walk.

---
 rtl/icache_ctrl_nway_if.sv | 44 ++++
 rtl/icache_ctrl_nway.sv | 150 +++++++++++++++
 tb/tb_icache_ctrl_nway.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_nway_if.sv
// Signal bundle between the N-way icache controller, the fetch stage, the tag/data
// arrays and the memory read channel.
interface icache_ctrl_nway_if #(
  parameter int unsigned N_WAYS      = 2,
  parameter int unsigned N_SETS      = 16,
  parameter int unsigned BLOCK_BEATS = 4
);
  localparam int unsigned SW = $clog2(N_SETS);
  localparam int unsigned BW = $clog2(BLOCK_BEATS);

  logic              i_start_check;
  logic [SW-1:0]     i_set_idx;
  logic [N_WAYS-1:0] i_hit_way;
  logic [N_WAYS-1:0] i_valid_way;
  logic              i_flush;
  logic              i_read_ack;
  logic              i_r_valid;
  logic              i_r_last;

  logic              o_stall;
  logic              o_start_read;
  logic              o_beat_we;
  logic [BW-1:0]     o_beat_idx;
  logic [N_WAYS-1:0] o_victim_way;
  logic              o_tag_we;
  logic              o_inv_en;
  logic [SW-1:0]     o_inv_set;
  logic              o_fill_err;
  logic              o_in_idle;

  modport master (
    output i_start_check, i_set_idx, i_hit_way, i_valid_way, i_flush, i_read_ack,
           i_r_valid, i_r_last,
    input  o_stall, o_start_read, o_beat_we, o_beat_idx, o_victim_way, o_tag_we,
           o_inv_en, o_inv_set, o_fill_err, o_in_idle
  );

  modport slave (
    input  i_start_check, i_set_idx, i_hit_way, i_valid_way, i_flush, i_read_ack,
           i_r_valid, i_r_last,
    output o_stall, o_start_read, o_beat_we, o_beat_idx, o_victim_way, o_tag_we,
           o_inv_en, o_inv_set, o_fill_err, o_in_idle
  );
endinterface

// File: rtl/icache_ctrl_nway.sv
// N-way set-associative instruction cache controller: lookup, miss line fill with
// victim selection (first invalid, else per-set round-robin) and whole-cache flush.
module icache_ctrl_nway #(
  parameter int unsigned N_WAYS      = 2,
  parameter int unsigned N_SETS      = 16,
  parameter int unsigned BLOCK_BEATS = 4
) (
  input logic               clk,
  input logic               arstn,
  icache_ctrl_nway_if.slave bus
);
  localparam int unsigned SW = $clog2(N_SETS);
  localparam int unsigned BW = $clog2(BLOCK_BEATS);
  localparam int unsigned WW = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam logic [BW:0]   NumBeats = (BW + 1)'(BLOCK_BEATS);
  localparam logic [BW:0]   LastCnt  = (BW + 1)'(BLOCK_BEATS - 1);
  localparam logic [SW-1:0] LastSet  = SW'(N_SETS - 1);

  typedef enum logic [2:0] {StIdle, StCompareTag, StReadReq, StFill, StFlush} state_e;

  state_e            state_q, state_d;
  logic [BW:0]       cnt_q, cnt_d;
  logic [SW-1:0]     set_cnt_q, set_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic [N_WAYS-1:0] victim_q, victim_d;
  logic              victim_rr_q, victim_rr_d;
  logic [WW-1:0]     rr_ptr_q [N_SETS];
  logic [WW-1:0]     rr_ptr_d [N_SETS];

  logic              hit;
  logic [N_WAYS-1:0] victim_sel;
  logic              victim_sel_rr;

  assign hit = |bus.i_hit_way;

  // Lowest invalid way wins; round-robin pointer only when the set is full.
  always_comb begin
    victim_sel    = '0;
    victim_sel_rr = 1'b1;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!bus.i_valid_way[w]) begin
        victim_sel    = '0;
        victim_sel[w] = 1'b1;
        victim_sel_rr = 1'b0;
      end
    end
    if (victim_sel_rr) victim_sel[rr_ptr_q[bus.i_set_idx]] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    set_cnt_d    = set_cnt_q;
    flush_pend_d = flush_pend_q;
    victim_d     = victim_q;
    victim_rr_d  = victim_rr_q;
    rr_ptr_d     = rr_ptr_q;

    bus.o_stall      = 1'b1;
    bus.o_start_read = 1'b0;
    bus.o_beat_we    = 1'b0;
    bus.o_tag_we     = 1'b0;
    bus.o_inv_en     = 1'b0;
    bus.o_fill_err   = 1'b0;

    if (bus.i_flush && (state_q != StIdle) && (state_q != StFlush)) flush_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (flush_pend_q || bus.i_flush) begin
          state_d      = StFlush;
          flush_pend_d = 1'b0;
          set_cnt_d    = '0;
        end else if (bus.i_start_check) begin
          state_d = StCompareTag;
        end
      end
      StCompareTag: begin
        bus.o_stall = ~hit;
        if (hit) begin
          state_d = StIdle;
        end else begin
          victim_d    = victim_sel;
          victim_rr_d = victim_sel_rr;
          state_d     = StReadReq;
        end
      end
      StReadReq: begin
        bus.o_start_read = 1'b1;
        if (bus.i_read_ack) begin
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (bus.i_r_valid) begin
          // Saturate so an overlong burst never wraps back into the write window.
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          bus.o_beat_we = (cnt_q < NumBeats);
          if (bus.i_r_last) begin
            if (cnt_q == LastCnt) begin
              bus.o_tag_we = arstn;
              state_d      = StCompareTag;
              if (victim_rr_q && (N_WAYS > 1)) begin
                rr_ptr_d[bus.i_set_idx] = rr_ptr_q[bus.i_set_idx] + WW'(1);
              end
            end else begin
              bus.o_fill_err = 1'b1;
              state_d        = StIdle;
            end
          end
        end
      end
      StFlush: begin
        bus.o_inv_en = 1'b1;
        set_cnt_d    = set_cnt_q + 1'b1;
        if (set_cnt_q == LastSet) begin
          state_d = StIdle;
          for (int s = 0; s < N_SETS; s++) rr_ptr_d[s] = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.o_beat_idx   = cnt_q[BW-1:0];
  assign bus.o_victim_way = victim_q;
  assign bus.o_inv_set    = set_cnt_q;
  assign bus.o_in_idle    = (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      set_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      victim_q     <= '0;
      victim_rr_q  <= 1'b0;
      for (int s = 0; s < N_SETS; s++) rr_ptr_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      set_cnt_q    <= set_cnt_d;
      flush_pend_q <= flush_pend_d;
      victim_q     <= victim_d;
      victim_rr_q  <= victim_rr_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Bench for icache_ctrl_nway: cycle table for hit/cold miss, directed corner sequences,
// then random lookups checked against a transaction-level victim/round-robin model.
module tb_icache_ctrl_nway;
  localparam int unsigned NW = 2;
  localparam int unsigned NS = 16;
  localparam int unsigned BB = 4;
  localparam int unsigned SW = $clog2(NS);

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  icache_ctrl_nway_if #(.N_WAYS(NW), .N_SETS(NS), .BLOCK_BEATS(BB)) bus ();

  icache_ctrl_nway #(.N_WAYS(NW), .N_SETS(NS), .BLOCK_BEATS(BB)) dut (
    .clk  (clk),
    .arstn(arstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int rr_m [NS];

  typedef struct packed {
    logic       start;
    logic [1:0] hit;
    logic [1:0] valid;
    logic       ack;
    logic       rv;
    logic       rl;
    logic       stall;
    logic       sr;
    logic       bwe;
    logic [1:0] bidx;
    logic [1:0] vict;
    logic       twe;
    logic       idle;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_start_check = 1'b0;
    bus.i_set_idx     = '0;
    bus.i_hit_way     = '0;
    bus.i_valid_way   = '0;
    bus.i_flush       = 1'b0;
    bus.i_read_ack    = 1'b0;
    bus.i_r_valid     = 1'b0;
    bus.i_r_last      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chkb({tag, "_stall"}, bus.o_stall, 1'b1);
    chkb({tag, "_idle"}, bus.o_in_idle, 1'b1);
    chk({tag, "_victim"}, 32'(bus.o_victim_way), 32'd0);
    chk({tag, "_beat_idx"}, 32'(bus.o_beat_idx), 32'd0);
    chk({tag, "_inv_set"}, 32'(bus.o_inv_set), 32'd0);
    chkb({tag, "_start_read"}, bus.o_start_read, 1'b0);
    chkb({tag, "_beat_we"}, bus.o_beat_we, 1'b0);
    chkb({tag, "_tag_we"}, bus.o_tag_we, 1'b0);
    chkb({tag, "_inv_en"}, bus.o_inv_en, 1'b0);
    chkb({tag, "_fill_err"}, bus.o_fill_err, 1'b0);
  endtask

  // Whole lookup transaction from IDLE back to IDLE; expectations from the model.
  task automatic lookup(input int s_idx, input logic [NW-1:0] valid, input bit is_hit,
                        input logic [NW-1:0] hway, input int ack_dly, input int nbeats,
                        input int gap_max, input int flush_at);
    logic [NW-1:0] exp_v;
    bit from_rr;
    bit ok;
    int g;
    from_rr = 1'b1;
    exp_v   = '0;
    for (int w = 0; w < NW; w++) begin
      if (from_rr && !valid[w]) begin
        exp_v[w] = 1'b1;
        from_rr  = 1'b0;
      end
    end
    if (from_rr) exp_v[rr_m[s_idx]] = 1'b1;

    bus.i_set_idx     = SW'(s_idx);
    bus.i_valid_way   = valid;
    bus.i_start_check = 1'b1;
    #1;
    chkb("lk_start_idle", bus.o_in_idle, 1'b1);
    tick();
    bus.i_start_check = 1'b0;
    bus.i_hit_way     = is_hit ? hway : '0;
    #1;
    chkb("lk_cmp_stall", bus.o_stall, !is_hit);
    chkb("lk_cmp_idle", bus.o_in_idle, 1'b0);
    tick();
    bus.i_hit_way = '0;
    if (is_hit) begin
      #1;
      chkb("lk_hit_ret_idle", bus.o_in_idle, 1'b1);
      return;
    end

    for (int d = 0; d <= ack_dly; d++) begin
      bus.i_read_ack = (d == ack_dly);
      #1;
      chkb("rdreq_start_read", bus.o_start_read, 1'b1);
      chk("rdreq_victim", 32'(bus.o_victim_way), 32'(exp_v));
      tick();
    end
    bus.i_read_ack = 1'b0;

    ok = (nbeats == BB);
    for (int b = 0; b < nbeats; b++) begin
      g = $urandom_range(gap_max, 0);
      for (int k = 0; k < g; k++) begin
        bus.i_r_valid = 1'b0;
        bus.i_flush   = 1'b0;
        #1;
        chkb("fill_gap_we", bus.o_beat_we, 1'b0);
        tick();
      end
      bus.i_r_valid = 1'b1;
      bus.i_r_last  = (b == nbeats - 1);
      bus.i_flush   = (b == flush_at);
      #1;
      chkb("fill_beat_we", bus.o_beat_we, (b < BB));
      if (b < BB) chk("fill_beat_idx", 32'(bus.o_beat_idx), 32'(b));
      if (b == nbeats - 1) begin
        chkb("fill_tag_we", bus.o_tag_we, ok);
        chkb("fill_err", bus.o_fill_err, !ok);
      end
      tick();
    end
    bus.i_r_valid = 1'b0;
    bus.i_r_last  = 1'b0;
    bus.i_flush   = 1'b0;

    if (ok) begin
      if (from_rr) rr_m[s_idx] = (rr_m[s_idx] + 1) % NW;
      bus.i_hit_way = exp_v;
      #1;
      chkb("refill_cmp_stall", bus.o_stall, 1'b0);
      tick();
      bus.i_hit_way = '0;
    end
    #1;
    chkb("lk_end_idle", bus.o_in_idle, 1'b1);
  endtask

  // Called in the IDLE cycle that leads into FLUSH.
  task automatic flush_walk();
    tick();
    bus.i_flush       = 1'b0;
    bus.i_start_check = 1'b0;
    for (int s = 0; s < NS; s++) begin
      bus.i_flush = (s == 5);
      #1;
      chkb("flush_inv_en", bus.o_inv_en, 1'b1);
      chk("flush_inv_set", 32'(bus.o_inv_set), 32'(s));
      chkb("flush_stall", bus.o_stall, 1'b1);
      chkb("flush_idle", bus.o_in_idle, 1'b0);
      tick();
    end
    bus.i_flush = 1'b0;
    #1;
    chkb("flush_exit_idle", bus.o_in_idle, 1'b1);
    chkb("flush_exit_inv_en", bus.o_inv_en, 1'b0);
    tick();
    #1;
    chkb("flush_no_rearm", bus.o_in_idle, 1'b1);
    for (int s = 0; s < NS; s++) rr_m[s] = 0;
  endtask

  int            r_set, r_ack, r_nb, r_fa;
  logic [NW-1:0] r_val, r_hw;
  bit            r_h;

  initial begin
    for (int s = 0; s < NS; s++) rr_m[s] = 0;
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'b10, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'b10, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'b10, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'b10, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'b10, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 2'b10, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b10, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b10, 1'b0, 1'b1};

    clear_inputs();
    arstn = 1'b0;
    repeat (3) tick();
    arstn = 1'b1;
    #1;
    check_reset_outputs("reset");

    // Hit then cold miss on set 3, cycle by cycle.
    for (int i = 0; i < 15; i++) begin
      bus.i_set_idx     = SW'(3);
      bus.i_start_check = vecs[i].start;
      bus.i_hit_way     = vecs[i].hit;
      bus.i_valid_way   = vecs[i].valid;
      bus.i_read_ack    = vecs[i].ack;
      bus.i_r_valid     = vecs[i].rv;
      bus.i_r_last      = vecs[i].rl;
      #1;
      chkb($sformatf("vec%0d_stall", i), bus.o_stall, vecs[i].stall);
      chkb($sformatf("vec%0d_start_read", i), bus.o_start_read, vecs[i].sr);
      chkb($sformatf("vec%0d_beat_we", i), bus.o_beat_we, vecs[i].bwe);
      chk($sformatf("vec%0d_beat_idx", i), 32'(bus.o_beat_idx), 32'(vecs[i].bidx));
      chk($sformatf("vec%0d_victim", i), 32'(bus.o_victim_way), 32'(vecs[i].vict));
      chkb($sformatf("vec%0d_tag_we", i), bus.o_tag_we, vecs[i].twe);
      chkb($sformatf("vec%0d_idle", i), bus.o_in_idle, vecs[i].idle);
      chkb($sformatf("vec%0d_fill_err", i), bus.o_fill_err, 1'b0);
      tick();
    end
    clear_inputs();

    // Round-robin on a full set 5; set 6 keeps its own pointer.
    repeat (3) lookup(5, 2'b11, 1'b0, 2'b00, 1, BB, 1, -1);
    lookup(6, 2'b11, 1'b0, 2'b00, 0, BB, 0, -1);

    // Short burst: error, pointer unchanged, then a good fill uses the same way.
    lookup(5, 2'b11, 1'b0, 2'b00, 0, 2, 0, -1);
    lookup(5, 2'b11, 1'b0, 2'b00, 0, BB, 0, -1);

    // Flush raised mid-fill is serviced after the fill; pointers cleared.
    lookup(2, 2'b00, 1'b0, 2'b00, 2, BB, 1, 1);
    flush_walk();
    lookup(6, 2'b11, 1'b0, 2'b00, 0, BB, 0, -1);

    // Flush beats a simultaneous lookup request in IDLE.
    bus.i_start_check = 1'b1;
    bus.i_flush       = 1'b1;
    flush_walk();

    // Reset in the middle of a fill, with a flush pending.
    lookup(9, 2'b11, 1'b0, 2'b00, 0, BB, 0, -1);
    bus.i_set_idx     = SW'(9);
    bus.i_valid_way   = 2'b11;
    bus.i_start_check = 1'b1;
    tick();
    bus.i_start_check = 1'b0;
    tick();
    bus.i_read_ack = 1'b1;
    bus.i_flush    = 1'b1;
    tick();
    bus.i_read_ack = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_r_valid  = 1'b1;
    #1;
    chkb("rstfill_beat0_we", bus.o_beat_we, 1'b1);
    tick();
    arstn = 1'b0;
    #1;
    chkb("rstfill_no_tag_we", bus.o_tag_we, 1'b0);
    tick();
    arstn = 1'b1;
    clear_inputs();
    #1;
    check_reset_outputs("rstfill");
    for (int s = 0; s < NS; s++) rr_m[s] = 0;
    tick();
    #1;
    chkb("rstfill_pend_cleared", bus.o_inv_en, 1'b0);
    lookup(9, 2'b11, 1'b0, 2'b00, 0, BB, 0, -1);

    // Random lookups against the model.
    for (int t = 0; t < 80; t++) begin
      r_set = $urandom_range(NS - 1, 0);
      r_val = NW'($urandom_range(3, 0));
      r_h   = ($urandom_range(3, 0) == 0);
      r_hw  = ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
      r_ack = $urandom_range(3, 0);
      r_nb  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(BB + 1, 1)) : BB;
      r_fa  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(r_nb - 1, 0)) : -1;
      lookup(r_set, r_val, r_h, r_hw, r_ack, r_nb, 2, r_fa);
      if (!r_h && r_fa >= 0) flush_walk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
